// File: rtl/fifo_tx_serializer.sv
// Pulls bytes from the upstream byte FIFO and shifts each one out as an
// asynchronous serial frame (start, 8 data LSB first, optional parity, stop).
module fifo_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        empty,
  input  logic [7:0]  DATAIN,
  output logic        rn,
  output logic        txd,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_next;
  logic [7:0]  shreg, shreg_next;
  logic        par_acc, par_next;
  logic [2:0]  bit_cnt, bit_next;
  logic [15:0] baud_cnt, baud_next;
  logic        rn_next;
  logic        txd_next;
  logic        busy_next;
  logic [15:0] frames_next;
  logic        baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);

  // All outputs are registered; reset drops the frame and forces the line idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= 8'h00;
      par_acc     <= 1'b0;
      bit_cnt     <= 3'd0;
      baud_cnt    <= 16'd0;
      rn          <= 1'b0;
      txd         <= 1'b1;
      busy        <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      state       <= state_next;
      shreg       <= shreg_next;
      par_acc     <= par_next;
      bit_cnt     <= bit_next;
      baud_cnt    <= baud_next;
      rn          <= rn_next;
      txd         <= txd_next;
      busy        <= busy_next;
      frames_sent <= frames_next;
    end
  end

  // Next-state logic; txd_next is the level for the bit that starts at the coming edge.
  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    par_next    = par_acc;
    bit_next    = bit_cnt;
    baud_next   = baud_cnt;
    rn_next     = 1'b0;
    txd_next    = txd;
    busy_next   = busy;
    frames_next = frames_sent;

    case (state)
      IDLE: begin
        txd_next  = 1'b1;
        baud_next = 16'd0;
        bit_next  = 3'd0;
        if (enable && !empty) begin
          state_next = FETCH;
          rn_next    = 1'b1;
          busy_next  = 1'b1;
        end
      end

      FETCH: begin
        state_next = LOAD;
      end

      LOAD: begin
        shreg_next = DATAIN;
        par_next   = ^DATAIN;
        txd_next   = 1'b0;
        baud_next  = 16'd0;
        bit_next   = 3'd0;
        state_next = START;
      end

      START: begin
        if (baud_last) begin
          baud_next  = 16'd0;
          txd_next   = shreg[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_next = 16'd0;
          if (bit_cnt == 3'd7) begin
            if (PARITY_EN) begin
              txd_next   = par_acc ^ PARITY_ODD;
              state_next = PARITY;
            end else begin
              txd_next   = 1'b1;
              state_next = STOP;
            end
          end else begin
            bit_next   = bit_cnt + 3'd1;
            shreg_next = {1'b0, shreg[7:1]};
            txd_next   = shreg[1];
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

      PARITY: begin
        if (baud_last) begin
          baud_next  = 16'd0;
          txd_next   = 1'b1;
          state_next = STOP;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

      // Chaining straight into FETCH keeps the inter-frame gap at two cycles.
      STOP: begin
        txd_next = 1'b1;
        if (baud_last) begin
          baud_next   = 16'd0;
          frames_next = frames_sent + 16'd1;
          if (enable && !empty) begin
            state_next = FETCH;
            rn_next    = 1'b1;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench: four serializer instances (different bit timing / parity)
// each fed by a small behavioural FIFO, with the tx line checked cycle by cycle.
module tb_fifo_tx_serializer;

  localparam int NDUT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        fifoClear;
  logic        enable     [NDUT];
  logic        empty      [NDUT];
  logic [7:0]  dataIn     [NDUT];
  logic        rn         [NDUT];
  logic        txd        [NDUT];
  logic        busy       [NDUT];
  logic [15:0] framesSent [NDUT];

  logic [7:0]  fifoMem [NDUT][16];
  logic [4:0]  wrPtr   [NDUT];
  logic [4:0]  rdPtr   [NDUT];

  int rnPulses     [NDUT] = '{default: 0};
  int rnViolations [NDUT] = '{default: 0};
  logic rnPrev     [NDUT] = '{default: 1'b0};

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;

  fifo_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable[0]), .empty(empty[0]), .DATAIN(dataIn[0]),
    .rn(rn[0]), .txd(txd[0]), .busy(busy[0]), .frames_sent(framesSent[0]));

  fifo_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clock(clock), .reset(reset), .enable(enable[1]), .empty(empty[1]), .DATAIN(dataIn[1]),
    .rn(rn[1]), .txd(txd[1]), .busy(busy[1]), .frames_sent(framesSent[1]));

  fifo_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
    .clock(clock), .reset(reset), .enable(enable[2]), .empty(empty[2]), .DATAIN(dataIn[2]),
    .rn(rn[2]), .txd(txd[2]), .busy(busy[2]), .frames_sent(framesSent[2]));

  fifo_tx_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut3 (
    .clock(clock), .reset(reset), .enable(enable[3]), .empty(empty[3]), .DATAIN(dataIn[3]),
    .rn(rn[3]), .txd(txd[3]), .busy(busy[3]), .frames_sent(framesSent[3]));

  // FIFO model: DATAOUT updates on the edge that samples rn.
  always_comb begin
    for (int i = 0; i < NDUT; i++) empty[i] = (wrPtr[i] == rdPtr[i]);
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NDUT; i++) begin
      if (fifoClear) begin
        rdPtr[i]  <= 5'd0;
        dataIn[i] <= 8'h00;
      end else if (rn[i] && !empty[i]) begin
        dataIn[i] <= fifoMem[i][rdPtr[i][3:0]];
        rdPtr[i]  <= rdPtr[i] + 5'd1;
      end
    end
  end

  // Read-strobe protocol monitor: never two high cycles in a row, never while empty.
  always @(negedge clock) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rn[i]) begin
        rnPulses[i] = rnPulses[i] + 1;
        if (rnPrev[i] || empty[i]) rnViolations[i] = rnViolations[i] + 1;
      end
      rnPrev[i] = rn[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] value);
    fifoMem[idx][wrPtr[idx][3:0]] = value;
    wrPtr[idx] = wrPtr[idx] + 5'd1;
  endtask

  // Returns at the negedge of the first start-bit cycle.
  task automatic waitStart(input int idx, input int maxCycles, output int highCycles, output int rnToStart);
    int rnCycle = -100;
    bit found = 1'b0;
    highCycles = 0;
    rnToStart  = -1;
    for (int n = 0; n < maxCycles; n++) begin
      @(negedge clock);
      if (rn[idx]) rnCycle = n;
      if (txd[idx] == 1'b0) begin
        found = 1'b1;
        rnToStart = n - rnCycle;
        break;
      end
      highCycles++;
    end
    if (!found) checkOutput($sformatf("dut%0d start timeout", idx), 32'd0, 32'd1);
  endtask

  task automatic expectFrame(input string tag, input int idx, input logic [7:0] value, input int cpb,
                             input int parBit, input int dropCycle);
    logic bits [11];
    logic [31:0] obs;
    logic [31:0] mask;
    int nbits;
    nbits = (parBit >= 0) ? 11 : 10;
    mask  = (32'd1 << cpb) - 32'd1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i + 1] = value[i];
    bits[9]  = (parBit >= 0) ? parBit[0] : 1'b1;
    bits[10] = 1'b1;
    checkOutput($sformatf("%s busy at start", tag), {31'd0, busy[idx]}, 32'd1);
    for (int b = 0; b < nbits; b++) begin
      obs = 32'd0;
      for (int k = 0; k < cpb; k++) begin
        if (b != 0 || k != 0) @(negedge clock);
        if (b * cpb + k == dropCycle) enable[idx] = 1'b0;
        obs[k] = txd[idx];
      end
      checkOutput($sformatf("%s bit%0d", tag, b), obs, bits[b] ? mask : 32'd0);
    end
  endtask

  task automatic checkIdle(input string tag, input int idx, input int frames, input int emptyExp);
    checkOutput($sformatf("%s busy", tag), {31'd0, busy[idx]}, 32'd0);
    checkOutput($sformatf("%s txd", tag), {31'd0, txd[idx]}, 32'd1);
    checkOutput($sformatf("%s frames_sent", tag), {16'd0, framesSent[idx]}, frames);
    checkOutput($sformatf("%s empty", tag), {31'd0, empty[idx]}, emptyExp);
  endtask

  initial begin
    int hc, rts, pulses0;
    logic [7:0] burst [7];
    burst = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};

    reset = 1'b0;
    fifoClear = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      enable[i] = 1'b0;
      wrPtr[i]  = 5'd0;
    end
    repeat (3) @(negedge clock);
    fifoClear = 1'b0;
    checkOutput("reset txd", {31'd0, txd[0]}, 32'd1);
    checkOutput("reset rn", {31'd0, rn[0]}, 32'd0);
    checkOutput("reset busy", {31'd0, busy[0]}, 32'd0);
    checkOutput("reset frames_sent", {16'd0, framesSent[0]}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Single 8'hA5 frame, 4 clocks per bit, no parity.
    pulses0 = rnPulses[0];
    applyStimulus(0, 8'hA5);
    enable[0] = 1'b1;
    waitStart(0, 50, hc, rts);
    checkOutput("a5 rn to start", rts, 32'd2);
    expectFrame("a5", 0, 8'hA5, 4, -1, -1);
    @(negedge clock);
    checkIdle("a5 end", 0, 1, 1);
    checkOutput("a5 rn pulses", rnPulses[0] - pulses0, 32'd1);

    // Even and odd parity on the same byte.
    applyStimulus(1, 8'hA5);
    enable[1] = 1'b1;
    waitStart(1, 50, hc, rts);
    checkOutput("even rn to start", rts, 32'd2);
    expectFrame("even", 1, 8'hA5, 4, 0, -1);
    @(negedge clock);
    checkIdle("even end", 1, 1, 1);

    applyStimulus(2, 8'hA5);
    enable[2] = 1'b1;
    waitStart(2, 50, hc, rts);
    expectFrame("odd", 2, 8'hA5, 4, 1, -1);
    @(negedge clock);
    checkIdle("odd end", 2, 1, 1);

    // One clock per bit.
    applyStimulus(3, 8'hFF);
    enable[3] = 1'b1;
    waitStart(3, 50, hc, rts);
    checkOutput("ff rn to start", rts, 32'd2);
    expectFrame("ff", 3, 8'hFF, 1, -1, -1);
    @(negedge clock);
    checkIdle("ff end", 3, 1, 1);

    // Seven queued bytes sent back to back.
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    pulses0 = rnPulses[0];
    for (int i = 0; i < 7; i++) applyStimulus(0, burst[i]);
    for (int f = 0; f < 7; f++) begin
      waitStart(0, 60, hc, rts);
      checkOutput($sformatf("burst%0d rn to start", f), rts, 32'd2);
      if (f > 0) checkOutput($sformatf("burst%0d gap", f), hc, 32'd2);
      expectFrame($sformatf("burst%0d", f), 0, burst[f], 4, -1, -1);
    end
    @(negedge clock);
    checkIdle("burst end", 0, 7, 1);
    repeat (20) @(negedge clock);
    checkOutput("burst rn pulses", rnPulses[0] - pulses0, 32'd7);

    // enable dropped in the middle of the second of three frames.
    pulses0 = rnPulses[0];
    applyStimulus(0, 8'h3C);
    applyStimulus(0, 8'hC3);
    applyStimulus(0, 8'h81);
    waitStart(0, 60, hc, rts);
    expectFrame("drop f1", 0, 8'h3C, 4, -1, -1);
    waitStart(0, 60, hc, rts);
    checkOutput("drop f2 gap", hc, 32'd2);
    expectFrame("drop f2", 0, 8'hC3, 4, -1, 13);
    @(negedge clock);
    checkIdle("drop end", 0, 9, 0);
    repeat (30) @(negedge clock);
    checkOutput("drop rn pulses", rnPulses[0] - pulses0, 32'd2);
    checkOutput("drop txd idle", {31'd0, txd[0]}, 32'd1);
    enable[0] = 1'b1;
    waitStart(0, 60, hc, rts);
    checkOutput("drop f3 rn to start", rts, 32'd2);
    expectFrame("drop f3", 0, 8'h81, 4, -1, -1);
    @(negedge clock);
    checkIdle("drop f3 end", 0, 10, 1);

    // Asynchronous reset in the middle of a data bit.
    applyStimulus(0, 8'h5A);
    waitStart(0, 60, hc, rts);
    repeat (6) @(negedge clock);
    checkOutput("pre-reset txd", {31'd0, txd[0]}, 32'd0);
    #1 reset = 1'b0;
    #1;
    checkOutput("async reset txd", {31'd0, txd[0]}, 32'd1);
    checkOutput("async reset rn", {31'd0, rn[0]}, 32'd0);
    checkOutput("async reset busy", {31'd0, busy[0]}, 32'd0);
    checkOutput("async reset frames_sent", {16'd0, framesSent[0]}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(0, 8'h96);
    waitStart(0, 60, hc, rts);
    checkOutput("post-reset rn to start", rts, 32'd2);
    expectFrame("post-reset", 0, 8'h96, 4, -1, -1);
    @(negedge clock);
    checkIdle("post-reset end", 0, 1, 1);

    checkOutput("rn violations dut0", rnViolations[0], 32'd0);
    checkOutput("rn violations dut1-3", rnViolations[1] + rnViolations[2] + rnViolations[3], 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
